// File: rtl/mem_pkg.sv
// Shared widths and the store-buffer entry type for the memory access unit.
package mem_pkg;

    localparam int DEFAULT_ADDR_W = 5;
    localparam int DEFAULT_DATA_W = 32;

    typedef struct packed {
        logic [DEFAULT_ADDR_W-1:0] addr;
        logic [DEFAULT_DATA_W-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/sb_fifo.sv
// Circular store buffer: entry storage, head/tail pointers, occupancy count.
// The forwarding view (all entries, head, count) exists only with MEM_ACCESS_SB_FWD_EN.
module sb_fifo
    import mem_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = sb_entry_t
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  entry_t                     push_entry,
    input  logic                       pop,
    output entry_t                     head_entry,
`ifdef MEM_ACCESS_SB_FWD_EN
    output entry_t                     entries [DEPTH],
    output logic [$clog2(DEPTH)-1:0]   head_ptr,
    output logic [$clog2(DEPTH+1)-1:0] count,
`endif
    output logic                       full,
    output logic                       empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    entry_t             storage [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   occupancy;

    // Storage is never cleared; slots outside head..head+count are ignored.
    always_ff @(posedge clk) begin
        if (push) begin
            storage[tail] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            if (push && !pop) begin
                occupancy <= occupancy + 1'b1;
            end else if (pop && !push) begin
                occupancy <= occupancy - 1'b1;
            end
        end
    end

    assign head_entry = storage[head];
    assign full       = (occupancy == CNT_W'(DEPTH));
    assign empty      = (occupancy == '0);

`ifdef MEM_ACCESS_SB_FWD_EN
    assign entries  = storage;
    assign head_ptr = head;
    assign count    = occupancy;
`endif

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit with a posted store buffer that drains into idle memory cycles.
// Define MEM_ACCESS_SB_FWD_EN to forward buffered stores to loads instead of stalling them.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int SB_DEPTH = 4,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int DATA_W   = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_datain,
    input  logic [DATA_W-1:0] mem_dataout,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              sb_empty
);
    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = $clog2(SB_DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t            push_entry;
    entry_t            head_entry;
    logic              full;
    logic              empty;
    logic              handshake;
    logic              load_accept;
    logic              push;
    logic              drain;
    logic [DATA_W-1:0] load_data;

`ifdef MEM_ACCESS_SB_FWD_EN
    entry_t            entries [SB_DEPTH];
    logic [PTR_W-1:0]  head_ptr;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  idx;
`endif

    sb_fifo #(
        .DEPTH   (SB_DEPTH),
        .entry_t (entry_t)
    ) u_sb_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (drain),
        .head_entry (head_entry),
`ifdef MEM_ACCESS_SB_FWD_EN
        .entries    (entries),
        .head_ptr   (head_ptr),
        .count      (count),
`endif
        .full       (full),
        .empty      (empty)
    );

`ifdef MEM_ACCESS_SB_FWD_EN
    assign req_ready = rst_n && !full;
`else
    // Without forwarding a load must wait until every older store has reached memory.
    assign req_ready = rst_n && !full && (req_we || empty);
`endif

    assign handshake   = req_valid && req_ready;
    assign load_accept = handshake && !req_we;
    assign push        = handshake && req_we;
    assign drain       = rst_n && !handshake && !empty;
    assign push_entry  = {req_addr, req_wdata};
    assign sb_empty    = empty;

    always_comb begin
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_datain = '0;
        if (load_accept) begin
            mem_addr = req_addr;
        end else if (drain) begin
            mem_we     = 1'b1;
            mem_addr   = head_entry.addr;
            mem_datain = head_entry.data;
        end
    end

`ifdef MEM_ACCESS_SB_FWD_EN
    // Walk oldest to youngest so the last match is the youngest store.
    always_comb begin
        load_data = mem_dataout;
        idx       = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            idx = head_ptr + PTR_W'(i);
            if (i < int'(count) && entries[idx].addr == req_addr) begin
                load_data = entries[idx].data;
            end
        end
    end
`else
    assign load_data = mem_dataout;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= load_accept;
            if (load_accept) begin
                rsp_data <= load_data;
            end
        end
    end

endmodule
